seq_divider: RTL

Sequential signed integer divider that computes quotient and remainder one bit per cycle by restoring division on operand magnitudes, with sign fix-up at the end. It is the inverse-direction companion to the team's sequential Booth multiplier and shares that block's load/enable driving style, so the same bench can feed both and cross-check them: product / multiplicand = multiplier, remainder 0. It sits beside the multiplier in the arithmetic datapath.

---
 rtl/seq_divider_if.sv | 26 ++
 rtl/seq_divider.sv | 123 ++++++++++++
 2 files changed

// File: rtl/seq_divider_if.sv
// Operand/result bundle for the sequential divider. The master drives
// operands and control, the slave (the divider) returns results and status.
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] R;
    logic             busy;
    logic             done;
    logic             dz;
    logic             ovf;

    modport master (
        output en, load, A, B,
        input  Q, R, busy, done, dz, ovf
    );

    modport slave (
        input  en, load, A, B,
        output Q, R, busy, done, dz, ovf
    );
endinterface

// File: rtl/seq_divider.sv
// Signed restoring divider, one quotient bit per cycle on operand magnitudes,
// with a single sign fix-up cycle. Truncating division: R takes the sign of A.
//
// state | meaning
// IDLE  | waiting for load after reset
// RUN   | WIDTH shift/trial-subtract iterations
// FIX   | apply quotient/remainder signs, raise done
// DONE  | results held until next load
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    seq_divider_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] r_q;
    logic [CW-1:0]    cnt_q;
    logic             sign_a_q;
    logic             sign_q_q;
    logic             ovf_pend_q;
    logic             busy_q;
    logic             done_q;
    logic             dz_q;
    logic             ovf_q;

    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             borrow;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;

    // Magnitudes are unsigned, so |MIN_NEG| = MIN_NEG is representable.
    always_comb begin
        mag_a   = bus.A[WIDTH-1] ? -bus.A : bus.A;
        mag_b   = bus.B[WIDTH-1] ? -bus.B : bus.B;
        shifted = {rem_q, quo_q[WIDTH-1]};
        {borrow, trial} = {1'b0, shifted} - {2'b00, dvs_q};
        rem_d   = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_d   = {quo_q[WIDTH-2:0], ~borrow};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            dvs_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            q_q        <= '0;
            r_q        <= '0;
            cnt_q      <= '0;
            sign_a_q   <= 1'b0;
            sign_q_q   <= 1'b0;
            ovf_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dz_q       <= 1'b0;
            ovf_q      <= 1'b0;
        end else if (bus.en) begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.load) begin
                        dvs_q      <= mag_b;
                        rem_q      <= '0;
                        quo_q      <= mag_a;
                        sign_a_q   <= bus.A[WIDTH-1];
                        sign_q_q   <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
                        ovf_pend_q <= (bus.A == MIN_NEG) && (bus.B == '1);
                        cnt_q      <= '0;
                        ovf_q      <= 1'b0;
                        if (bus.B == '0) begin
                            q_q     <= '1;
                            r_q     <= bus.A;
                            dz_q    <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            dz_q    <= 1'b0;
                            done_q  <= 1'b0;
                            busy_q  <= 1'b1;
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    q_q     <= sign_q_q ? -quo_q : quo_q;
                    r_q     <= sign_a_q ? -rem_q : rem_q;
                    ovf_q   <= ovf_pend_q;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.Q    = q_q;
    assign bus.R    = r_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.dz   = dz_q;
    assign bus.ovf  = ovf_q;
endmodule
